// File: rtl/emmc_ddr_tx_sequencer.sv
// eMMC DDR write-block sequencer. It drives the DAT-line ODDR cells with a start bit, the
// payload, a per-line rise/fall CRC16 pair and an end bit. The card clock stops while the write stream is starved.
module emmc_ddr_tx_sequencer #(
   parameter int unsigned BLK_W = 9
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic             bus8_i,
   input  logic [BLK_W-1:0] blk_words_i,
   input  logic [15:0]      wdata_i,
   input  logic             wvalid_i,
   output logic             wready_o,
   output logic [7:0]       ddr_d1_o,
   output logic [7:0]       ddr_d2_o,
   output logic             ddr_ce_o,
   output logic [7:0]       dat_oe_o,
   output logic             sdclk_en_o,
   output logic             busy_o,
   output logic             done_o
);
   localparam int unsigned LINES = 8;
   localparam int unsigned CRC_W = 16;
   localparam int unsigned CNT_W = 4;
   localparam logic [CRC_W-1:0] CRC_POLY = 16'h1021;

   typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_CRC, ST_END} state_t;

   state_t             state, state_n;
   logic               bus8, bus8_n;
   logic [BLK_W-1:0]   words, words_n;
   logic               phase_b, phase_b_n;
   logic [CNT_W-1:0]   crc_cnt, crc_cnt_n;
   logic [7:0]         hold, hold_n;
   logic               end_q, end_n;
   logic [CRC_W-1:0]   crc_r [LINES];
   logic [CRC_W-1:0]   crc_f [LINES];
   logic [CRC_W-1:0]   crc_r_n [LINES];
   logic [CRC_W-1:0]   crc_f_n [LINES];
   logic [7:0]         d1_n, d2_n, oe_n;
   logic               ce_n, sclk_n, busy_n, done_n;
   logic [7:0]         mask, rise, fall;
   logic               pair_en;

   function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c, input logic b);
      crc_step = {c[CRC_W-2:0], 1'b0} ^ ((c[CRC_W-1] ^ b) ? CRC_POLY : '0);
   endfunction

   // Word-consuming DATA cycle: every cycle on bus8, phase A on bus4.
   assign wready_o = (state == ST_DATA) && (bus8 || !phase_b);

   always_comb begin
      state_n   = state;
      bus8_n    = bus8;
      words_n   = words;
      phase_b_n = phase_b;
      crc_cnt_n = crc_cnt;
      hold_n    = hold;
      end_n     = 1'b0;
      crc_r_n   = crc_r;
      crc_f_n   = crc_f;
      d1_n      = ddr_d1_o;
      d2_n      = ddr_d2_o;
      oe_n      = dat_oe_o;
      ce_n      = 1'b1;
      sclk_n    = 1'b1;
      busy_n    = busy_o;
      done_n    = 1'b0;
      mask      = bus8 ? 8'hFF : 8'h0F;
      rise      = '0;
      fall      = '0;
      pair_en   = 1'b0;
      case (state)
         ST_IDLE: begin
            d1_n   = '1;
            d2_n   = '1;
            oe_n   = '0;
            busy_n = 1'b0;
            done_n = end_q;
            if (start_i && !abort_i && (blk_words_i != '0)) begin
               state_n   = ST_START;
               bus8_n    = bus8_i;
               words_n   = blk_words_i;
               phase_b_n = 1'b0;
               crc_cnt_n = '0;
               for (int i = 0; i < LINES; i++) begin
                  crc_r_n[i] = '0;
                  crc_f_n[i] = '0;
               end
            end
         end
         ST_START: begin
            d1_n    = ~mask;
            d2_n    = ~mask;
            oe_n    = mask;
            busy_n  = 1'b1;
            state_n = ST_DATA;
         end
         ST_DATA: begin
            oe_n   = mask;
            busy_n = 1'b1;
            if (wready_o && !wvalid_i) begin
               // Starved: freeze the ODDR cells and the card clock until a word arrives.
               ce_n   = 1'b0;
               sclk_n = 1'b0;
            end else begin
               pair_en = 1'b1;
               if (bus8) begin
                  rise = wdata_i[15:8];
                  fall = wdata_i[7:0];
               end else if (!phase_b) begin
                  rise      = {4'h0, wdata_i[15:12]};
                  fall      = {4'h0, wdata_i[11:8]};
                  hold_n    = wdata_i[7:0];
                  phase_b_n = 1'b1;
               end else begin
                  rise      = {4'h0, hold[7:4]};
                  fall      = {4'h0, hold[3:0]};
                  phase_b_n = 1'b0;
               end
               if (bus8 || phase_b) begin
                  if (words == BLK_W'(1)) state_n = ST_CRC;
                  else                    words_n = words - BLK_W'(1);
               end
               d1_n = rise | ~mask;
               d2_n = fall | ~mask;
            end
         end
         ST_CRC: begin
            oe_n      = mask;
            busy_n    = 1'b1;
            crc_cnt_n = crc_cnt + CNT_W'(1);
            for (int i = 0; i < LINES; i++) begin
               d1_n[i]    = crc_r[i][CRC_W-1] | ~mask[i];
               d2_n[i]    = crc_f[i][CRC_W-1] | ~mask[i];
               crc_r_n[i] = {crc_r[i][CRC_W-2:0], 1'b0};
               crc_f_n[i] = {crc_f[i][CRC_W-2:0], 1'b0};
            end
            if (crc_cnt == '1) state_n = ST_END;
         end
         ST_END: begin
            d1_n    = '1;
            d2_n    = '1;
            oe_n    = mask;
            busy_n  = 1'b1;
            end_n   = 1'b1;
            state_n = ST_IDLE;
         end
         default: state_n = ST_IDLE;
      endcase
      if (pair_en) begin
         for (int i = 0; i < LINES; i++) begin
            crc_r_n[i] = crc_step(crc_r[i], rise[i]);
            crc_f_n[i] = crc_step(crc_f[i], fall[i]);
         end
      end
      // Abort overrides everything, including a stall and a same-cycle start.
      if (abort_i && (state != ST_IDLE)) begin
         state_n = ST_IDLE;
         d1_n    = '1;
         d2_n    = '1;
         oe_n    = '0;
         ce_n    = 1'b1;
         sclk_n  = 1'b1;
         busy_n  = 1'b0;
         done_n  = 1'b0;
         end_n   = 1'b0;
         for (int i = 0; i < LINES; i++) begin
            crc_r_n[i] = '0;
            crc_f_n[i] = '0;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state      <= ST_IDLE;
         bus8       <= 1'b0;
         words      <= '0;
         phase_b    <= 1'b0;
         crc_cnt    <= '0;
         hold       <= '0;
         end_q      <= 1'b0;
         for (int i = 0; i < LINES; i++) begin
            crc_r[i] <= '0;
            crc_f[i] <= '0;
         end
         ddr_d1_o   <= '1;
         ddr_d2_o   <= '1;
         dat_oe_o   <= '0;
         ddr_ce_o   <= 1'b1;
         sdclk_en_o <= 1'b1;
         busy_o     <= 1'b0;
         done_o     <= 1'b0;
      end else begin
         state      <= state_n;
         bus8       <= bus8_n;
         words      <= words_n;
         phase_b    <= phase_b_n;
         crc_cnt    <= crc_cnt_n;
         hold       <= hold_n;
         end_q      <= end_n;
         crc_r      <= crc_r_n;
         crc_f      <= crc_f_n;
         ddr_d1_o   <= d1_n;
         ddr_d2_o   <= d2_n;
         dat_oe_o   <= oe_n;
         ddr_ce_o   <= ce_n;
         sdclk_en_o <= sclk_n;
         busy_o     <= busy_n;
         done_o     <= done_n;
      end
   end
endmodule

// File: tb/tb_emmc_ddr_tx_sequencer.sv
// Bench for emmc_ddr_tx_sequencer: directed and random blocks checked beat-by-beat
// against a frame model whose CRCs come from polynomial long division.
module tb_emmc_ddr_tx_sequencer;
   localparam int unsigned BLK_W = 9;

   logic             clk_i = 1'b0;
   logic             rst_ni;
   logic             start_i, abort_i, bus8_i, wvalid_i;
   logic [BLK_W-1:0] blk_words_i;
   logic [15:0]      wdata_i;
   logic             wready_o, ddr_ce_o, sdclk_en_o, busy_o, done_o;
   logic [7:0]       ddr_d1_o, ddr_d2_o, dat_oe_o;

   int               n_assert = 0;
   int               n_fail   = 0;
   logic [15:0]      words[$];
   logic [7:0]       exp_d1[$], exp_d2[$], exp_oe[$];

   emmc_ddr_tx_sequencer #(.BLK_W(BLK_W)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i), .abort_i(abort_i),
      .bus8_i(bus8_i), .blk_words_i(blk_words_i), .wdata_i(wdata_i), .wvalid_i(wvalid_i),
      .wready_o(wready_o), .ddr_d1_o(ddr_d1_o), .ddr_d2_o(ddr_d2_o), .ddr_ce_o(ddr_ce_o),
      .dat_oe_o(dat_oe_o), .sdclk_en_o(sdclk_en_o), .busy_o(busy_o), .done_o(done_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // CRC as the remainder of M(x)*x^16 divided by x^16+x^12+x^5+1.
   function automatic logic [15:0] crc_ref(input bit msg[$]);
      bit          m[$];
      logic [16:0] g = 17'h11021;
      logic [15:0] r;
      m = msg;
      for (int k = 0; k < 16; k++) m.push_back(1'b0);
      for (int i = 0; i + 16 < m.size(); i++)
         if (m[i]) for (int j = 0; j < 17; j++) m[i+j] = m[i+j] ^ g[16-j];
      for (int k = 0; k < 16; k++) r[15-k] = m[m.size()-16+k];
      return r;
   endfunction

   function automatic void push_beat(input logic [7:0] a, input logic [7:0] b, input logic [7:0] oe);
      exp_d1.push_back(a);
      exp_d2.push_back(b);
      exp_oe.push_back(oe);
   endfunction

   // Expected bus frame: start, payload beats, 16 CRC beats, end.
   function automatic void build_expected(input bit b8);
      logic [7:0]  mask, r, f, t1, t2;
      logic [15:0] w;
      logic [15:0] cr[8], cf[8];
      bit          q1[$], q2[$];
      int          nd;
      mask = b8 ? 8'hFF : 8'h0F;
      exp_d1.delete(); exp_d2.delete(); exp_oe.delete();
      push_beat(~mask, ~mask, mask);
      foreach (words[k]) begin
         w = words[k];
         if (b8) push_beat(w[15:8], w[7:0], mask);
         else begin
            push_beat({4'hF, w[15:12]}, {4'hF, w[11:8]}, mask);
            push_beat({4'hF, w[7:4]}, {4'hF, w[3:0]}, mask);
         end
      end
      nd = exp_d1.size() - 1;
      for (int i = 0; i < 8; i++) begin
         q1.delete(); q2.delete();
         for (int b = 1; b <= nd; b++) begin
            t1 = exp_d1[b]; t2 = exp_d2[b];
            q1.push_back(t1[i]); q2.push_back(t2[i]);
         end
         cr[i] = crc_ref(q1);
         cf[i] = crc_ref(q2);
      end
      for (int k = 0; k < 16; k++) begin
         r = ~mask; f = ~mask;
         for (int i = 0; i < 8; i++)
            if (mask[i]) begin r[i] = cr[i][15-k]; f[i] = cf[i][15-k]; end
         push_beat(r, f, mask);
      end
      push_beat(8'hFF, 8'hFF, mask);
   endfunction

   task automatic run_block(input bit b8, input int stall_idx, input int stall_len, input int gap_pct,
                            input int abort_at, input int busy_start_at, input int reset_at);
      int         idx = 0, beats = 0, stalls = 0, exp_stalls = 0, busy_cyc = 0, stall_left;
      bit         seen = 0, fin = 0, abort_pend = 0, sb_pend = 0, sb_used = 0;
      logic [7:0] last_d1 = 8'hFF, last_d2 = 8'hFF;
      build_expected(b8);
      stall_left = stall_len;
      @(negedge clk_i);
      start_i = 1'b1; bus8_i = b8; blk_words_i = BLK_W'(words.size());
      @(negedge clk_i);
      start_i = 1'b0; bus8_i = 1'($urandom); blk_words_i = BLK_W'($urandom);
      for (int cyc = 0; cyc < 1000 && !fin; cyc++) begin
         if (abort_pend) begin
            abort_i = 1'b0; wvalid_i = 1'b0;
            chk("abort_busy", 32'(busy_o), 32'(0));
            chk("abort_oe", 32'(dat_oe_o), 32'(0));
            chk("abort_d1", 32'(ddr_d1_o), 32'hFF);
            chk("abort_done", 32'(done_o), 32'(0));
            repeat (4) begin
               @(negedge clk_i);
               chk("abort_nodone", 32'(done_o), 32'(0));
               chk("abort_idle", 32'(busy_o), 32'(0));
            end
            return;
         end
         if (sb_pend) begin start_i = 1'b0; sb_pend = 0; end
         if (busy_o) begin
            seen = 1; busy_cyc++;
            chk("done_while_busy", 32'(done_o), 32'(0));
            if (ddr_ce_o) begin
               if (beats < exp_d1.size()) begin
                  chk("beat_d1", 32'(ddr_d1_o), 32'(exp_d1[beats]));
                  chk("beat_d2", 32'(ddr_d2_o), 32'(exp_d2[beats]));
                  chk("beat_oe", 32'(dat_oe_o), 32'(exp_oe[beats]));
               end else chk("extra_beat", 32'(beats), 32'(exp_d1.size()));
               chk("sdclk_on", 32'(sdclk_en_o), 32'(1));
               beats++;
            end else begin
               stalls++;
               chk("stall_sdclk", 32'(sdclk_en_o), 32'(0));
               chk("stall_d1_frozen", 32'(ddr_d1_o), 32'(last_d1));
               chk("stall_d2_frozen", 32'(ddr_d2_o), 32'(last_d2));
            end
            last_d1 = ddr_d1_o; last_d2 = ddr_d2_o;
         end else if (seen) begin
            fin = 1;
            chk("done_pulse", 32'(done_o), 32'(1));
         end else chk("done_before", 32'(done_o), 32'(0));
         if (!fin && reset_at >= 0 && beats == reset_at && busy_o) begin
            #2 rst_ni = 1'b0;
            #1;
            chk("rst_d1", 32'(ddr_d1_o), 32'hFF);
            chk("rst_d2", 32'(ddr_d2_o), 32'hFF);
            chk("rst_oe", 32'(dat_oe_o), 32'(0));
            chk("rst_ce", 32'(ddr_ce_o), 32'(1));
            chk("rst_sdclk", 32'(sdclk_en_o), 32'(1));
            chk("rst_busy", 32'(busy_o), 32'(0));
            chk("rst_wready", 32'(wready_o), 32'(0));
            wvalid_i = 1'b0;
            @(negedge clk_i);
            rst_ni = 1'b1;
            repeat (25) begin
               @(negedge clk_i);
               chk("rst_nodone", 32'(done_o), 32'(0));
               chk("rst_idle", 32'(busy_o), 32'(0));
            end
            return;
         end
         if (!fin && abort_at >= 0 && beats == abort_at && busy_o) begin
            abort_i = 1'b1; abort_pend = 1;
         end
         if (!fin && !sb_used && busy_start_at >= 0 && beats == busy_start_at && busy_o) begin
            start_i = 1'b1; bus8_i = ~b8; blk_words_i = BLK_W'(3); sb_pend = 1; sb_used = 1;
         end
         if (wready_o && idx < words.size()) begin
            if (stall_left > 0 && idx == stall_idx) begin
               wvalid_i = 1'b0; stall_left--; exp_stalls++;
            end else if ($urandom_range(99) < gap_pct) begin
               wvalid_i = 1'b0; exp_stalls++;
            end else begin
               wvalid_i = 1'b1; wdata_i = words[idx]; idx++;
            end
         end else begin
            wvalid_i = 1'b0; wdata_i = 16'($urandom);
         end
         if (!fin) @(negedge clk_i);
      end
      chk("block_finished", 32'(fin), 32'(1));
      chk("beat_count", 32'(beats), 32'(exp_d1.size()));
      chk("busy_cycles", 32'(busy_cyc), 32'(exp_d1.size() + stall_len + exp_stalls - stall_len));
      chk("stall_cycles", 32'(stalls), 32'(exp_stalls));
      chk("words_used", 32'(idx), 32'(words.size()));
      @(negedge clk_i);
      chk("done_one_cycle", 32'(done_o), 32'(0));
   endtask

   initial begin
      rst_ni = 1'b0; start_i = 1'b0; abort_i = 1'b0; bus8_i = 1'b0;
      blk_words_i = '0; wdata_i = '0; wvalid_i = 1'b0;
      repeat (2) @(negedge clk_i);
      chk("reset_d1", 32'(ddr_d1_o), 32'hFF);
      chk("reset_d2", 32'(ddr_d2_o), 32'hFF);
      chk("reset_oe", 32'(dat_oe_o), 32'(0));
      chk("reset_ce", 32'(ddr_ce_o), 32'(1));
      chk("reset_sdclk", 32'(sdclk_en_o), 32'(1));
      chk("reset_busy", 32'(busy_o), 32'(0));
      chk("reset_done", 32'(done_o), 32'(0));
      chk("reset_wready", 32'(wready_o), 32'(0));
      rst_ni = 1'b1;
      @(negedge clk_i);

      // bus8, single zero word
      words = '{16'h0000};
      run_block(1'b1, -1, 0, 0, -1, -1, -1);
      // bus4, two words, upper lines idle
      words = '{16'hA5C3, 16'h0F0F};
      run_block(1'b0, -1, 0, 0, -1, -1, -1);
      // bus8, four words, unstalled then stalled 3 cycles before word 3
      words = '{16'h1234, 16'hBEEF, 16'h5A5A, 16'hC001};
      run_block(1'b1, -1, 0, 0, -1, -1, -1);
      run_block(1'b1, 2, 3, 0, -1, -1, -1);
      // abort during CRC, then an immediate fresh block
      run_block(1'b1, -1, 0, 0, 10, -1, -1);
      words = '{16'h8001, 16'h7E3C, 16'hFFFF};
      run_block(1'b1, -1, 0, 0, -1, -1, -1);
      // zero-length start is ignored
      @(negedge clk_i);
      start_i = 1'b1; bus8_i = 1'b1; blk_words_i = '0;
      @(negedge clk_i);
      start_i = 1'b0;
      repeat (3) begin
         @(negedge clk_i);
         chk("zero_len_busy", 32'(busy_o), 32'(0));
         chk("zero_len_oe", 32'(dat_oe_o), 32'(0));
         chk("zero_len_d1", 32'(ddr_d1_o), 32'hFF);
         chk("zero_len_wready", 32'(wready_o), 32'(0));
      end
      // start while busy is ignored
      words = '{16'h0102, 16'h0304, 16'h0506};
      run_block(1'b0, -1, 0, 0, -1, 3, -1);
      // async reset mid-DATA
      words = '{16'hDEAD, 16'hBEEF, 16'hCAFE, 16'hF00D};
      run_block(1'b1, -1, 0, 0, -1, -1, 2);
      // random blocks with random valid gaps
      repeat (8) begin
         bit b8;
         int n;
         b8 = 1'($urandom_range(1));
         n  = int'($urandom_range(6, 1));
         words.delete();
         for (int k = 0; k < n; k++) words.push_back(16'($urandom));
         run_block(b8, -1, 0, 25, -1, -1, -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
